// File: rtl/song_recorder.sv
// Write side of the song RAM: while the master FSM is in COMPOSER it measures each
// held note or rest in beats and streams one 16-bit entry per segment into RAM.
module song_recorder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int MAX_ENTRIES = 128,
  parameter int MAX_DUR     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat,
  input  logic [1:0]            master_state,
  input  logic                  record_button,
  input  logic [5:0]            key_note,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [15:0]           write_payload,
  output logic                  done_recording,
  output logic                  recording
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [1:0]    COMPOSER   = 2'b01;
  localparam logic [5:0]    DUR_MAX    = 6'(MAX_DUR);
  localparam logic [CW-1:0] LAST_ENTRY = CW'(MAX_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [5:0]            cur_note, cur_note_n;
  logic [5:0]            dur, dur_n, dur_inc;
  logic [CW-1:0]         count, count_n, count_m1;
  logic                  write_enable_n, done_recording_n, recording_n;
  logic [ADDR_WIDTH-1:0] write_address_n;
  logic [15:0]           write_payload_n;
  logic                  start, stop, key_change, rec_write;

  // A rest is flagged in bit 15 and carries a zero note field.
  function automatic logic [15:0] make_entry(input logic [5:0] note, input logic [5:0] d);
    return {(note == 6'd0), note, d, 3'b000};
  endfunction

  assign start      = record_button && (master_state == COMPOSER);
  assign stop       = record_button || (master_state != COMPOSER);
  assign key_change = (key_note != cur_note);
  assign dur_inc    = beat ? ((dur == DUR_MAX) ? DUR_MAX : dur + 6'd1) : dur;
  assign count_m1   = count - CW'(1);
  // Zero-length segments on a key change are glitches and never reach RAM.
  assign rec_write  = (state == REC) && !stop &&
                      ((key_change && (dur_inc != 6'd0)) || (!key_change && (dur_inc == DUR_MAX)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? REC : IDLE;
      REC: begin
        if (stop) begin
          next_state = FLUSH;
        end else if (rec_write && (count == LAST_ENTRY)) begin
          next_state = DONE;
        end else begin
          next_state = REC;
        end
      end
      FLUSH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cur_note_n       = cur_note;
    dur_n            = dur;
    count_n          = count;
    write_enable_n   = 1'b0;
    write_address_n  = write_address;
    write_payload_n  = write_payload;
    done_recording_n = 1'b0;
    recording_n      = (next_state == REC) || (next_state == FLUSH);
    case (state)
      IDLE: begin
        if (start) begin
          cur_note_n = key_note;
          dur_n      = 6'd0;
          count_n    = '0;
        end else begin
          count_n = count;
        end
      end
      REC: begin
        if (rec_write) begin
          write_enable_n  = 1'b1;
          write_address_n = count[ADDR_WIDTH-1:0];
          write_payload_n = make_entry(cur_note, dur_inc);
          count_n         = count + CW'(1);
        end else begin
          count_n = count;
        end
        if (stop) begin
          dur_n = dur;
        end else if (key_change) begin
          cur_note_n = key_note;
          dur_n      = 6'd0;
        end else if (dur_inc == DUR_MAX) begin
          dur_n = 6'd0;
        end else begin
          dur_n = dur_inc;
        end
      end
      FLUSH: begin
        if (dur != 6'd0) begin
          write_enable_n  = 1'b1;
          write_address_n = count[ADDR_WIDTH-1:0];
          write_payload_n = make_entry(cur_note, dur);
          count_n         = count + CW'(1);
        end else begin
          count_n = count;
        end
        dur_n = 6'd0;
      end
      DONE: begin
        if (count != '0) begin
          done_recording_n = 1'b1;
          write_address_n  = count_m1[ADDR_WIDTH-1:0];
        end else begin
          done_recording_n = 1'b0;
        end
      end
      default: begin
        dur_n = 6'd0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_note       <= 6'd0;
      dur            <= 6'd0;
      count          <= '0;
      write_enable   <= 1'b0;
      write_address  <= '0;
      write_payload  <= 16'h0000;
      done_recording <= 1'b0;
      recording      <= 1'b0;
    end else begin
      cur_note       <= cur_note_n;
      dur            <= dur_n;
      count          <= count_n;
      write_enable   <= write_enable_n;
      write_address  <= write_address_n;
      write_payload  <= write_payload_n;
      done_recording <= done_recording_n;
      recording      <= recording_n;
    end
  end

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: directed takes with literal expected entries plus
// randomized traffic, all checked against a segment-level reference model.
module tb_song_recorder;

  localparam int AW   = 7;
  localparam int MAXE = 4;
  localparam int MAXD = 63;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          beat = 1'b0;
  logic [1:0]    master_state = 2'b00;
  logic          record_button = 1'b0;
  logic [5:0]    key_note = 6'd0;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [15:0]   write_payload;
  logic          done_recording;
  logic          recording;

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase 0 idle, 1 recording, 2 flushing, 3 finishing
  int m_phase, m_note, m_dur, m_cnt;
  int exp_we, exp_addr, exp_payload, exp_done, exp_rec;

  int log_addr[$];
  int log_data[$];
  int done_seen, done_addr;

  song_recorder #(.ADDR_WIDTH(AW), .MAX_ENTRIES(MAXE), .MAX_DUR(MAXD)) dut (
    .clk(clk), .reset(reset), .beat(beat), .master_state(master_state),
    .record_button(record_button), .key_note(key_note),
    .write_enable(write_enable), .write_address(write_address),
    .write_payload(write_payload), .done_recording(done_recording),
    .recording(recording)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_note = 0; m_dur = 0; m_cnt = 0;
    exp_we = 0; exp_addr = 0; exp_payload = 0; exp_done = 0; exp_rec = 0;
  endtask

  task automatic emit(input int d);
    exp_we      = 1;
    exp_addr    = m_cnt;
    exp_payload = ((m_note == 0) ? 32768 : 0) + m_note * 512 + d * 8;
    m_cnt++;
    if (m_cnt == MAXE) m_phase = 3;
  endtask

  task automatic model_step(input logic b, input logic rb, input logic [1:0] ms, input logic [5:0] kn);
    int nd;
    exp_we = 0;
    exp_done = 0;
    case (m_phase)
      0: if (rb && ms == 2'b01) begin m_phase = 1; m_note = kn; m_dur = 0; m_cnt = 0; end
      1: begin
        if (rb || ms != 2'b01) m_phase = 2;
        else begin
          nd = b ? ((m_dur + 1 > MAXD) ? MAXD : m_dur + 1) : m_dur;
          if (int'(kn) != m_note) begin
            if (nd > 0) emit(nd);
            m_note = kn;
            m_dur = 0;
          end else if (nd == MAXD) begin
            emit(nd);
            m_dur = 0;
          end else m_dur = nd;
        end
      end
      2: begin
        if (m_dur > 0) emit(m_dur);
        m_dur = 0;
        m_phase = 3;
      end
      default: begin
        if (m_cnt > 0) begin exp_done = 1; exp_addr = m_cnt - 1; end
        m_phase = 0;
      end
    endcase
    exp_rec = (m_phase == 1 || m_phase == 2) ? 1 : 0;
  endtask

  task automatic compare();
    check("we",      32'(write_enable),   32'(exp_we));
    check("addr",    32'(write_address),  32'(exp_addr));
    check("payload", 32'(write_payload),  32'(exp_payload));
    check("done",    32'(done_recording), 32'(exp_done));
    check("rec",     32'(recording),      32'(exp_rec));
    if (write_enable) begin
      log_addr.push_back(int'(write_address));
      log_data.push_back(int'(write_payload));
    end
    if (done_recording) begin
      done_seen++;
      done_addr = int'(write_address);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_seen = 0;
    done_addr = -1;
  endtask

  task automatic cyc(input logic b, input logic rb, input logic [1:0] ms, input logic [5:0] kn);
    beat = b; record_button = rb; master_state = ms; key_note = kn;
    @(posedge clk);
    model_step(b, rb, ms, kn);
    @(negedge clk);
    compare();
  endtask

  // Each beat is preceded by a quiet cycle so key changes land between beats.
  task automatic hold(input logic [5:0] kn, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      cyc(1'b0, 1'b0, 2'b01, kn);
      cyc(1'b1, 1'b0, 2'b01, kn);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b01, 6'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_we",   32'(write_enable),   32'd0);
    check("rst_addr", 32'(write_address),  32'd0);
    check("rst_data", 32'(write_payload),  32'd0);
    check("rst_done", 32'(done_recording), 32'd0);
    check("rst_rec",  32'(recording),      32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int idx, input int addr, input int data);
    if (idx < log_data.size()) begin
      check({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
      check({tag, "_data"}, 32'(log_data[idx]), 32'(data));
    end else begin
      check({tag, "_missing"}, 32'(log_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [5:0] kn_r;
    logic [5:0] notes [4];
    notes[0] = 6'd0; notes[1] = 6'd5; notes[2] = 6'd17; notes[3] = 6'd63;
    clear_log();
    do_reset();

    // two notes then a record press
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd23);
    hold(6'd23, 5);
    hold(6'd24, 5);
    cyc(1'b0, 1'b1, 2'b01, 6'd24);
    idle(3);
    check("t1_n", 32'(log_data.size()), 32'd2);
    check_entry("t1_e0", 0, 0, 16'h2E28);
    check_entry("t1_e1", 1, 1, 16'h3028);
    check("t1_done", 32'(done_seen), 32'd1);
    check("t1_done_addr", 32'(done_addr), 32'd1);

    // rest then note, ended by leaving COMPOSER
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd0);
    hold(6'd0, 10);
    hold(6'd22, 5);
    cyc(1'b0, 1'b0, 2'b00, 6'd22);
    idle(3);
    check("t2_n", 32'(log_data.size()), 32'd2);
    check_entry("t2_e0", 0, 0, 16'h8050);
    check_entry("t2_e1", 1, 1, 16'h2C28);
    check("t2_done_addr", 32'(done_addr), 32'd1);
    check("t2_rec", 32'(recording), 32'd0);

    // saturation at 63 beats
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd30);
    hold(6'd30, 70);
    cyc(1'b0, 1'b1, 2'b01, 6'd30);
    idle(3);
    check("t3_n", 32'(log_data.size()), 32'd2);
    check_entry("t3_e0", 0, 0, 16'h3DF8);
    check_entry("t3_e1", 1, 1, 16'h3C38);

    // glitch filter and beat coincident with key change
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd40);
    hold(6'd40, 2);
    cyc(1'b0, 1'b0, 2'b01, 6'd41);
    cyc(1'b0, 1'b0, 2'b01, 6'd40);
    hold(6'd40, 2);
    cyc(1'b1, 1'b0, 2'b01, 6'd50);
    hold(6'd50, 1);
    cyc(1'b0, 1'b1, 2'b01, 6'd50);
    idle(3);
    check("t4_n", 32'(log_data.size()), 32'd3);
    check_entry("t4_e0", 0, 0, 16'h5010);
    check_entry("t4_e1", 1, 1, 16'h5018);
    check_entry("t4_e2", 2, 2, 16'h6408);

    // entry limit: a note change on every beat
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd10);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 2'b01, (i % 2 == 0) ? 6'd11 : 6'd10);
    idle(3);
    check("t5_n", 32'(log_data.size()), 32'd4);
    check_entry("t5_e3", 3, 3, 16'h1608);
    check("t5_done", 32'(done_seen), 32'd1);
    check("t5_done_addr", 32'(done_addr), 32'd3);

    // empty take
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd7);
    cyc(1'b0, 1'b1, 2'b01, 6'd7);
    idle(4);
    check("t6_n", 32'(log_data.size()), 32'd0);
    check("t6_done", 32'(done_seen), 32'd0);

    // reset mid-take, then a fresh take restarts at address 0
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd5);
    hold(6'd5, 1);
    cyc(1'b0, 1'b0, 2'b01, 6'd6);
    hold(6'd6, 1);
    cyc(1'b0, 1'b0, 2'b01, 6'd7);
    check("t7_pre_n", 32'(log_data.size()), 32'd2);
    do_reset();
    idle(4);
    check("t7_done", 32'(done_seen), 32'd0);
    clear_log();
    cyc(1'b0, 1'b1, 2'b01, 6'd9);
    hold(6'd9, 1);
    cyc(1'b0, 1'b1, 2'b01, 6'd9);
    idle(3);
    check("t7_n", 32'(log_data.size()), 32'd1);
    check_entry("t7_e0", 0, 0, 16'h1208);

    // randomized traffic against the model
    kn_r = 6'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) kn_r = notes[$urandom_range(0, 3)];
      if ($urandom_range(0, 1499) == 0) do_reset();
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : 2'b01, kn_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Write side of the song RAM interface that song_player reads.
- While the master FSM is in COMPOSER, it samples the live key note, measures each note or rest in beats, and streams one 16-bit entry per segment into RAM.
- When recording ends it pulses done_recording, so the player can latch the last written address as the song's max address.

Parameters:
- ADDR_WIDTH, 7: RAM address width.
- MAX_ENTRIES, 128: entries per song, must be ≤ 2^ADDR_WIDTH.
- MAX_DUR, 63: duration saturation value; must fit the 6-bit duration field.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- beat  in  1  one-clk tempo pulse.
- master_state  in  2  00 JAM_SESH, 01 COMPOSER, 10 SONG_PLAYER.
- record_button  in  1  debounced one-clk pulse; toggles recording.
- key_note  in  6  currently held note; 0 means no key (rest).
- write_enable  out  1  RAM write strobe, one clk per entry.
- write_address  out  ADDR_WIDTH  RAM address of the entry.
- write_payload  out  16  entry = {is_rest[15], note[14:9], duration[8:3], 3'b000}.
- done_recording  out  1  one-clk pulse at end of take.
- recording  out  1  high in REC and FLUSH.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; entry counter 0; cur_note 0; dur 0.
- Output registering: all outputs are registered. An entry appears on write_* exactly 1 clk after the cycle its triggering event is sampled.
- States: IDLE, REC, FLUSH, DONE.
- IDLE:
  - record_button=1 with master_state=COMPOSER → REC; cur_note←key_note; dur←0; count←0.
  - record_button in any other master_state is ignored.
- REC, per clk, in this priority order:
  - (a) Stop condition: record_button=1, or master_state≠COMPOSER → FLUSH. The beat and key change in that same clk are ignored.
  - (b) Beat: if beat=1, dur_next=min(dur+1, MAX_DUR); otherwise dur_next=dur.
  - (c) Key change: if key_note≠cur_note:
    - with dur_next>0: write {cur_note==0, cur_note, dur_next, 000}; cur_note←key_note; dur←0.
    - with dur_next=0: cur_note←key_note silently, no write (glitch filter).
  - (d) Saturation: else if dur_next==MAX_DUR, write the entry and reset dur←0; the same note continues as a new entry.
  - (e) Otherwise dur←dur_next.
  - At most one write per clk. Beat and key change in the same clk: the beat counts toward the old note.
- Rest encoding: is_rest=1 and note field=0 when cur_note=0.
- Address: write_address = count; count increments after each write.
  - A write to address MAX_ENTRIES-1 → DONE directly. No wrap, no further writes.
- FLUSH (1 clk): if dur>0, write the final segment; then → DONE.
- DONE (1 clk):
  - if count>0: done_recording=1 and write_address = last written address (count-1); write_enable=0.
  - if count=0: no pulse.
  - → IDLE.
- Boundaries:
  - record_button in FLUSH/DONE is ignored.
  - reset mid-take aborts immediately with no done pulse. RAM contents are left as written.
  - beat in IDLE has no effect.
  - write_payload holds its last value when write_enable=0.

Test Plan:
- Reset mid-REC after 2 writes → next clk all outputs 0, state IDLE, no done_recording; a new take restarts at address 0.
- COMPOSER, record press, key_note=23 held 5 beats, then key_note=24 held 5 beats, then record press → writes addr0={0,23,5,0}=0x2E28 and addr1={0,24,5,0}=0x3028; done_recording 1 clk with write_address=1.
- key_note=0 held 10 beats, then 22 held 5 beats, then master_state→JAM_SESH → addr0=0x8050 (rest, dur 10), addr1=0x2C28; done with address 1; recording falls.
- Note 30 held 70 beats, then stop → addr0={0,30,63,0}, addr1={0,30,7,0}; no entry lost at the saturation boundary.
- key_note changes 40→41→40 within one beat gap (0 beats accrued on 41) → no entry for 41. Also: a beat coincident with a key change adds 1 to the old note's duration.
- MAX_ENTRIES=4, toggle notes every beat → exactly 4 writes (addr 0–3), then done with address 3 and no 5th write. A record press with no beats before stop → no writes, no done pulse.
